// File: rtl/flush_response_filter.sv
// Response filter for a flushable request path: counts live and stale requests in flight and
// absorbs responses to flushed work. Optional sticky error port under FLUSH_RSP_FILTER_ERR_EN.
module flush_response_filter #(
    parameter type T              = logic,
    parameter int  MaxOutstanding = 4,
    parameter int  CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            req_valid_i,
    input  logic            req_ready_i,
    output logic            req_gate_o,
    input  logic            rsp_valid_i,
    output logic            rsp_ready_o,
    input  T                rsp_data_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output T                rsp_data_o,
    output logic [CntW-1:0] outstanding_o,
`ifdef FLUSH_RSP_FILTER_ERR_EN
    output logic            err_o,
`endif
    output logic            dropping_o
);

    logic [CntW-1:0] live_q, live_d;
    logic [CntW-1:0] stale_q, stale_d;
    logic            out_full_q, out_full_d;
    T                out_data_q, out_data_d;

    logic            req_hs;
    logic            rsp_hs;
    logic            rsp_unexpected;
    logic [CntW:0]   total;
    logic [CntW:0]   flush_total;

    // One extra bit so the sum of both counters can never alias.
    assign total = {1'b0, live_q} + {1'b0, stale_q};

    assign req_gate_o     = total < (CntW + 1)'(MaxOutstanding);
    assign rsp_ready_o    = flush_i | (stale_q != '0) | ~out_full_q | rsp_ready_i;
    assign req_hs         = req_valid_i & req_ready_i & req_gate_o;
    assign rsp_hs         = rsp_valid_i & rsp_ready_o;
    assign rsp_unexpected = rsp_hs & (total == '0);

    assign rsp_valid_o   = out_full_q;
    assign rsp_data_o    = out_data_q;
    assign outstanding_o = live_q;
    assign dropping_o    = (stale_q != '0);

    always_comb begin
        live_d      = live_q;
        stale_d     = stale_q;
        out_full_d  = out_full_q;
        out_data_d  = out_data_q;
        flush_total = total + {{CntW{1'b0}}, req_hs};

        if (flush_i) begin
            // Everything in flight, including a same-cycle request, becomes stale.
            if (rsp_hs && (total != '0)) begin
                flush_total = flush_total - (CntW + 1)'(1);
            end
            live_d     = '0;
            stale_d    = flush_total[CntW-1:0];
            out_full_d = 1'b0;
        end else begin
            if (out_full_q && rsp_ready_i) begin
                out_full_d = 1'b0;
            end
            if (rsp_hs) begin
                if (stale_q != '0) begin
                    stale_d = stale_q - CntW'(1);
                end else if (live_q != '0) begin
                    live_d     = live_q - CntW'(1);
                    out_full_d = 1'b1;
                    out_data_d = rsp_data_i;
                end
            end
            if (req_hs) begin
                live_d = live_d + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            live_q     <= '0;
            stale_q    <= '0;
            out_full_q <= 1'b0;
            out_data_q <= '0;
        end else begin
            live_q     <= live_d;
            stale_q    <= stale_d;
            out_full_q <= out_full_d;
            out_data_q <= out_data_d;
        end
    end

`ifdef FLUSH_RSP_FILTER_ERR_EN
    logic err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (rsp_unexpected) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    logic unused_unexpected;
    assign unused_unexpected = rsp_unexpected;
`endif

`ifndef SYNTHESIS
    unexpected_rsp_a : assert property (@(posedge clk_i) disable iff (!rst_ni) !rsp_unexpected)
        else $warning("flush_response_filter: response with nothing outstanding");
`endif

endmodule
